// File: rtl/mult_row_sequencer_if.sv
// rtl/mult_row_sequencer_if.sv - start/busy/done handshake and operand/result bundle for mult_row_sequencer
interface mult_row_sequencer_if #(
    parameter int WIDTH = 8
) ();
    logic                   start;
    logic [WIDTH-1:0]       m;
    logic [WIDTH-1:0]       q;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, m, q,
        input  busy, done, product
    );

    modport slave (
        input  start, m, q,
        output busy, done, product
    );
endinterface

// File: rtl/mult_row_sequencer.sv
// rtl/mult_row_sequencer.sv - iterative unsigned multiplier retiring two multiplier bits per clock (optional MULT_ZERO_SKIP_EN early finish)
module mult_row_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    mult_row_sequencer_if.slave bus
);
    localparam int ROWS  = WIDTH / 2;
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW    = 2 * WIDTH;

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("mult_row_sequencer: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      product_q, product_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [1:0]         q_pair;
    logic [WIDTH+1:0]   row;
    logic [PW-1:0]      row_sh;
    logic [PW-1:0]      acc_sum;
    logic               last_row;
    logic               finish;
`ifdef MULT_ZERO_SKIP_EN
    logic [WIDTH-1:0]   q_rem;
`endif

    // Row datapath: m * q[2i+1:2i], weighted by 4^i, added into the accumulator
    always_comb begin
        q_pair   = q_q[{idx_q, 1'b0} +: 2];
        row      = {2'b00, m_q} * {{WIDTH{1'b0}}, q_pair};
        row_sh   = PW'(row) << {idx_q, 1'b0};
        acc_sum  = acc_q + row_sh;
        last_row = (idx_q == IDX_W'(ROWS - 1));
`ifdef MULT_ZERO_SKIP_EN
        // Multiplier bits not yet consumed once this row is retired
        q_rem    = q_q >> (2 * (int'(idx_q) + 1));
        finish   = last_row || (q_rem == '0);
`else
        finish   = last_row;
`endif
    end

    // Next-state and register update decisions for IDLE/RUN/DONE
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        product_d = product_q;
        idx_d     = idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    m_d       = bus.m;
                    q_d       = bus.q;
                    acc_d     = '0;
                    idx_d     = '0;
                    product_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                idx_d = idx_q + IDX_W'(1);
                if (finish) begin
                    product_d = acc_sum;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_mult_row_sequencer.sv
// tb/tb_mult_row_sequencer.sv - self-checking bench for mult_row_sequencer at WIDTH=8 and WIDTH=16
module tb_mult_row_sequencer;
    logic clk;
    logic rst;

    int passed;
    int total;

    logic        s_busy;
    logic        s_done;
    logic [31:0] s_prod;

    mult_row_sequencer_if #(.WIDTH(8))  bus8 ();
    mult_row_sequencer_if #(.WIDTH(16)) bus16 ();

    mult_row_sequencer #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    mult_row_sequencer #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected edges from accept to done, from the multiplier value alone
    function automatic int lat_of(input logic [15:0] qv, input int w);
        int k;
`ifdef MULT_ZERO_SKIP_EN
        k = 1;
        while ((k < w / 2) && ((qv >> (2 * k)) != 16'd0)) k++;
`else
        k = w / 2;
`endif
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w16, input logic st, input logic [15:0] mv, input logic [15:0] qv);
        if (w16) begin
            bus16.start = st;
            bus16.m     = mv;
            bus16.q     = qv;
        end else begin
            bus8.start = st;
            bus8.m     = mv[7:0];
            bus8.q     = qv[7:0];
        end
    endtask

    task automatic sample(input bit w16);
        if (w16) begin
            s_busy = bus16.busy;
            s_done = bus16.done;
            s_prod = bus16.product;
        end else begin
            s_busy = bus8.busy;
            s_done = bus8.done;
            s_prod = {16'd0, bus8.product};
        end
    endtask

    // One isolated multiplication with full timing checks
    task automatic run_op(input bit w16, input logic [15:0] mv_in, input logic [15:0] qv_in, input string name);
        logic [15:0] mv;
        logic [15:0] qv;
        logic [31:0] exp_p;
        int lat;
        mv    = w16 ? mv_in : {8'd0, mv_in[7:0]};
        qv    = w16 ? qv_in : {8'd0, qv_in[7:0]};
        exp_p = 32'(mv) * 32'(qv);
        lat   = lat_of(qv, w16 ? 16 : 8);
        drive(w16, 1'b1, mv, qv);
        tick();
        sample(w16);
        total++;
        if (s_busy !== 1'b1) $display("FAIL %s busy_after_E0: got %0b expected 1", name, s_busy);
        else passed++;
        total++;
        if (s_prod !== 32'd0) $display("FAIL %s product_in_run: got %0d expected 0", name, s_prod);
        else passed++;
        drive(w16, 1'b0, 16'($urandom), 16'($urandom));
        for (int e = 1; e <= lat; e++) begin
            tick();
            sample(w16);
            if (e < lat) begin
                total++;
                if (s_done !== 1'b0) $display("FAIL %s early_done E%0d: got %0b expected 0", name, e, s_done);
                else passed++;
            end else begin
                total++;
                if (s_done !== 1'b1) $display("FAIL %s done_at_E%0d: got %0b expected 1", name, e, s_done);
                else passed++;
                total++;
                if (s_prod !== exp_p) $display("FAIL %s product: got %0d expected %0d", name, s_prod, exp_p);
                else passed++;
            end
        end
        tick();
        sample(w16);
        total++;
        if ((s_busy !== 1'b0) || (s_done !== 1'b0))
            $display("FAIL %s idle_after_done: got busy=%0b done=%0b expected 0 0", name, s_busy, s_done);
        else passed++;
        total++;
        if (s_prod !== exp_p) $display("FAIL %s product_held: got %0d expected %0d", name, s_prod, exp_p);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0);
        repeat (2) tick();
        sample(1'b0);
        total++;
        if ((s_busy !== 1'b0) || (s_done !== 1'b0) || (s_prod !== 32'd0))
            $display("FAIL reset_state8: got busy=%0b done=%0b product=%0d expected 0 0 0", s_busy, s_done, s_prod);
        else passed++;
        sample(1'b1);
        total++;
        if ((s_busy !== 1'b0) || (s_done !== 1'b0) || (s_prod !== 32'd0))
            $display("FAIL reset_state16: got busy=%0b done=%0b product=%0d expected 0 0 0", s_busy, s_done, s_prod);
        else passed++;
        rst = 1'b0;
        tick();
        sample(1'b0);
        total++;
        if (s_busy !== 1'b0) $display("FAIL idle_after_release: got busy=%0b expected 0", s_busy);
        else passed++;
    endtask

    task automatic test_basic();
        run_op(1'b0, 16'd13, 16'd11, "basic_13x11");
        run_op(1'b0, 16'hFF, 16'hFF, "max_255x255");
        run_op(1'b1, 16'hFFFF, 16'hFFFF, "max16");
    endtask

    task automatic test_zero();
        run_op(1'b0, 16'hA5, 16'h00, "zero_q");
        run_op(1'b0, 16'h00, 16'hFF, "zero_m");
        run_op(1'b0, 16'h21, 16'h03, "small_q3");
        run_op(1'b0, 16'h21, 16'h0F, "small_q15");
    endtask

    task automatic test_ignore_start();
        int lat;
        lat = lat_of(16'd9, 8);
        drive(1'b0, 1'b1, 16'd7, 16'd9);
        tick();
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        for (int e = 1; e <= lat; e++) begin
            if (e == 2) drive(1'b0, 1'b1, 16'd1, 16'd1);
            tick();
            drive(1'b0, 1'b0, 16'd0, 16'd0);
        end
        sample(1'b0);
        total++;
        if (s_done !== 1'b1) $display("FAIL ignore_done_pulse: got %0b expected 1", s_done);
        else passed++;
        drive(1'b0, 1'b1, 16'd1, 16'd1);
        tick();
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        sample(1'b0);
        total++;
        if (s_busy !== 1'b0) $display("FAIL ignore_start_in_done: got busy=%0b expected 0", s_busy);
        else passed++;
        total++;
        if (s_prod !== 32'd63) $display("FAIL ignore_product: got %0d expected 63", s_prod);
        else passed++;
        run_op(1'b0, 16'd1, 16'd1, "after_ignore_1x1");
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 16'd200, 16'd150);
        tick();
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        repeat (2) tick();
        #3;
        rst = 1'b1;
        #1;
        sample(1'b0);
        total++;
        if ((s_busy !== 1'b0) || (s_done !== 1'b0) || (s_prod !== 32'd0))
            $display("FAIL async_reset: got busy=%0b done=%0b product=%0d expected 0 0 0", s_busy, s_done, s_prod);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            sample(1'b0);
            total++;
            if (s_done !== 1'b0) $display("FAIL no_done_in_reset cycle %0d: got %0b expected 0", i, s_done);
            else passed++;
        end
        rst = 1'b0;
        tick();
        run_op(1'b0, 16'd3, 16'd5, "after_reset_3x5");
    endtask

    // Continuous start: each result must appear after its modelled latency, then a gap of one IDLE cycle
    task automatic test_back_to_back(input bit w16, input int n);
        logic [15:0] mv;
        logic [15:0] qv;
        logic [31:0] exp_p;
        int lat;
        int w;
        w  = w16 ? 16 : 8;
        mv = 16'($urandom);
        qv = 16'($urandom);
        if (!w16) begin
            mv[15:8] = 8'd0;
            qv[15:8] = 8'd0;
        end
        drive(w16, 1'b1, mv, qv);
        for (int v = 0; v < n; v++) begin
            exp_p = 32'(mv) * 32'(qv);
            lat   = lat_of(qv, w);
            tick();
            sample(w16);
            total++;
            if (s_busy !== 1'b1) $display("FAIL b2b w%0d vec%0d busy: got %0b expected 1", w, v, s_busy);
            else passed++;
            drive(w16, 1'b1, 16'($urandom), 16'($urandom));
            for (int e = 1; e <= lat; e++) begin
                tick();
                sample(w16);
                total++;
                if (s_done !== (e == lat))
                    $display("FAIL b2b w%0d vec%0d done E%0d: got %0b expected %0b", w, v, e, s_done, (e == lat));
                else passed++;
            end
            total++;
            if (s_prod !== exp_p)
                $display("FAIL b2b w%0d vec%0d product m=%0d q=%0d: got %0d expected %0d", w, v, mv, qv, s_prod, exp_p);
            else passed++;
            tick();
            sample(w16);
            total++;
            if (s_busy !== 1'b0) $display("FAIL b2b w%0d vec%0d idle_gap: got busy=%0b expected 0", w, v, s_busy);
            else passed++;
            mv = 16'($urandom);
            qv = 16'($urandom);
            if (!w16) begin
                mv[15:8] = 8'd0;
                qv[15:8] = 8'd0;
            end
            if (($urandom_range(0, 7) == 0)) qv = qv & 16'h000F;
            drive(w16, (v != n - 1), mv, qv);
        end
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_basic();
        test_zero();
        test_ignore_start();
        test_async_reset();
        test_back_to_back(1'b0, 2000);
        test_back_to_back(1'b1, 2000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
